// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl - fetch/decode/execute sequencer for the program counter.
//
// Runs each instruction from program memory through fetch, decode and
// execute. It resolves the branch opcodes (JMP, JZE, JNE, JCY, BSR, RET) and
// owns the return stack used by BSR/RET. It drives the PC datapath with a
// hold/increment/load command and a load target.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_enable     run enable; low freezes state and forces strobes to 0
//   i_ir         instruction word from program memory
//   i_ir_valid   i_ir holds the word at i_pc_cur (only looked at in FETCH)
//   i_ccr        ALU flags: [3] N, [2] Z, [1] unused, [0] CY
//   i_pc_cur     current PC register value
//   o_fetch_en   program-memory read request
//   o_exec_en    one-cycle execute strobe for non-branch instructions
//   o_pc_op      00 hold, 01 increment, 10 load o_pc_target
//   o_pc_target  load address, non-zero only while o_pc_op = 10
//   o_stack_cnt  occupied return-stack entries
//   o_err_ovf    sticky: BSR issued with the stack full
//   o_err_unf    sticky: RET issued with the stack empty
//
// state  | meaning
// IDLE   | after reset, waiting for enable
// FETCH  | reading memory, latch ir on ir_valid
// DECODE | resolve JMP/BSR/RET, route the rest
// COND   | conditional jump resolved on this cycle's flags
// EXEC   | datapath executes a non-branch instruction
module pc_seq_ctrl #(
  parameter int ADDR_W      = 12,
  parameter int INSTR_W     = 24,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_enable,
  input  logic [INSTR_W-1:0]             i_ir,
  input  logic                           i_ir_valid,
  input  logic [3:0]                     i_ccr,
  input  logic [ADDR_W-1:0]              i_pc_cur,
  output logic                           o_fetch_en,
  output logic                           o_exec_en,
  output logic [1:0]                     o_pc_op,
  output logic [ADDR_W-1:0]              o_pc_target,
  output logic [$clog2(STACK_DEPTH):0]   o_stack_cnt,
  output logic                           o_err_ovf,
  output logic                           o_err_unf
);

  localparam int CNT_W = $clog2(STACK_DEPTH) + 1;
  localparam int IDX_W = CNT_W - 1;
  localparam int OPC_W = INSTR_W - ADDR_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_COND   = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;

  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(12'h800);
  localparam logic [OPC_W-1:0] OP_JZE = OPC_W'(12'h801);
  localparam logic [OPC_W-1:0] OP_JNE = OPC_W'(12'h802);
  localparam logic [OPC_W-1:0] OP_JCY = OPC_W'(12'h803);
  localparam logic [OPC_W-1:0] OP_RET = OPC_W'(12'h804);
  localparam logic [OPC_W-1:0] OP_BSR = OPC_W'(12'h805);

  logic [2:0]         r_state;
  logic [INSTR_W-1:0] r_ir_q;
  logic [ADDR_W-1:0]  r_stack [STACK_DEPTH];
  logic [CNT_W-1:0]   r_stack_cnt;
  logic               r_err_ovf;
  logic               r_err_unf;

  logic [2:0]         w_state_nxt;
  logic [OPC_W-1:0]   w_opc;
  logic [ADDR_W-1:0]  w_imm;
  logic               w_full;
  logic               w_empty;
  logic [IDX_W-1:0]   w_tos_idx;
  logic [IDX_W-1:0]   w_push_idx;
  logic [ADDR_W-1:0]  w_tos;
  logic               w_cond_ok;
  logic               w_ld_ir;
  logic               w_push;
  logic               w_pop;
  logic               w_set_ovf;
  logic               w_set_unf;
  logic               w_fetch_en;
  logic               w_exec_en;
  logic [1:0]         w_pc_op;
  logic [ADDR_W-1:0]  w_pc_target;
  logic               w_unused;

  assign w_opc      = r_ir_q[INSTR_W-1:ADDR_W];
  assign w_imm      = r_ir_q[ADDR_W-1:0];
  assign w_full     = (r_stack_cnt == CNT_W'(STACK_DEPTH));
  assign w_empty    = (r_stack_cnt == '0);
  // With an empty stack the index wraps; the value is never used then.
  assign w_tos_idx  = IDX_W'(r_stack_cnt - CNT_W'(1));
  assign w_push_idx = IDX_W'(r_stack_cnt);
  assign w_tos      = r_stack[w_tos_idx];
  assign w_unused   = i_ccr[1];

  // Flags are taken from the COND cycle, one cycle after decode, so the
  // ALU has settled from the previous instruction.
  always_comb begin
    w_cond_ok = 1'b0;
    case (w_opc)
      OP_JZE:  w_cond_ok = i_ccr[2];
      OP_JNE:  w_cond_ok = i_ccr[3];
      OP_JCY:  w_cond_ok = i_ccr[0];
      default: w_cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fetch_en  = 1'b0;
    w_exec_en   = 1'b0;
    w_pc_op     = PC_HOLD;
    w_pc_target = '0;
    w_ld_ir     = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_set_ovf   = 1'b0;
    w_set_unf   = 1'b0;
    if (i_enable) begin
      case (r_state)
        S_IDLE: w_state_nxt = S_FETCH;
        S_FETCH: begin
          w_fetch_en = 1'b1;
          if (i_ir_valid) begin
            w_ld_ir     = 1'b1;
            w_state_nxt = S_DECODE;
          end
        end
        S_DECODE: begin
          w_state_nxt = S_FETCH;
          case (w_opc)
            OP_JMP: begin
              w_pc_op     = PC_LOAD;
              w_pc_target = w_imm;
            end
            OP_JZE, OP_JNE, OP_JCY: w_state_nxt = S_COND;
            OP_RET: begin
              if (!w_empty) begin
                w_pop       = 1'b1;
                w_pc_op     = PC_LOAD;
                w_pc_target = w_tos;
              end else begin
                w_set_unf = 1'b1;
                w_pc_op   = PC_INC;
              end
            end
            OP_BSR: begin
              if (!w_full) begin
                w_push      = 1'b1;
                w_pc_op     = PC_LOAD;
                // Relative call; carry out of the address width is dropped.
                w_pc_target = i_pc_cur + w_imm;
              end else begin
                w_set_ovf = 1'b1;
                w_pc_op   = PC_INC;
              end
            end
            default: w_state_nxt = S_EXEC;
          endcase
        end
        S_COND: begin
          w_state_nxt = S_FETCH;
          if (w_cond_ok) begin
            w_pc_op     = PC_LOAD;
            w_pc_target = w_imm;
          end else begin
            w_pc_op = PC_INC;
          end
        end
        S_EXEC: begin
          w_exec_en   = 1'b1;
          w_pc_op     = PC_INC;
          w_state_nxt = S_FETCH;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ir_q      <= '0;
      r_stack_cnt <= '0;
      r_err_ovf   <= 1'b0;
      r_err_unf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_ir) begin
        r_ir_q <= i_ir;
      end
      if (w_push) begin
        r_stack_cnt <= r_stack_cnt + CNT_W'(1);
      end else if (w_pop) begin
        r_stack_cnt <= r_stack_cnt - CNT_W'(1);
      end
      if (w_set_ovf) begin
        r_err_ovf <= 1'b1;
      end
      if (w_set_unf) begin
        r_err_unf <= 1'b1;
      end
    end
  end

  // Stack storage needs no reset: only entries below the count are read.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) begin
      r_stack[w_push_idx] <= i_pc_cur + ADDR_W'(1);
    end
  end

  assign o_fetch_en  = w_fetch_en;
  assign o_exec_en   = w_exec_en;
  assign o_pc_op     = w_pc_op;
  assign o_pc_target = w_pc_target;
  assign o_stack_cnt = r_stack_cnt;
  assign o_err_ovf   = r_err_ovf;
  assign o_err_unf   = r_err_unf;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
module tb_pc_seq_ctrl;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        valid = 1'b0;
  logic [23:0] ir = '0;
  logic [3:0]  ccr = '0;
  logic [11:0] pc = '0;

  logic        fetch_en;
  logic        exec_en;
  logic [1:0]  pc_op;
  logic [11:0] pc_target;
  logic [2:0]  stack_cnt;
  logic        err_ovf;
  logic        err_unf;

  int n_checks = 0;
  int n_fail   = 0;

  pc_seq_ctrl #(.ADDR_W(12), .INSTR_W(24), .STACK_DEPTH(SD)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_enable    (en),
    .i_ir        (ir),
    .i_ir_valid  (valid),
    .i_ccr       (ccr),
    .i_pc_cur    (pc),
    .o_fetch_en  (fetch_en),
    .o_exec_en   (exec_en),
    .o_pc_op     (pc_op),
    .o_pc_target (pc_target),
    .o_stack_cnt (stack_cnt),
    .o_err_ovf   (err_ovf),
    .o_err_unf   (err_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic e, input logic v,
                       input logic [23:0] i, input logic [3:0] c, input logic [11:0] p);
    @(negedge clk);
    rst = r; en = e; valid = v; ir = i; ccr = c; pc = p;
    #1;
  endtask

  task automatic check_out(input string tag, input logic f, input logic x,
                           input logic [1:0] op, input logic [11:0] tg,
                           input logic [2:0] cnt, input logic ov, input logic un);
    chk({tag, ".fetch_en"},  fetch_en,  f);
    chk({tag, ".exec_en"},   exec_en,   x);
    chk({tag, ".pc_op"},     pc_op,     op);
    chk({tag, ".pc_target"}, pc_target, tg);
    chk({tag, ".stack_cnt"}, stack_cnt, cnt);
    chk({tag, ".err_ovf"},   err_ovf,   ov);
    chk({tag, ".err_unf"},   err_unf,   un);
  endtask

  typedef struct packed {
    logic        rst, en, valid;
    logic [23:0] ir;
    logic [3:0]  ccr;
    logic [11:0] pc;
    logic        f, x;
    logic [1:0]  op;
    logic [11:0] tg;
    logic [2:0]  cnt;
    logic        ov, un;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic e, input logic v,
                              input logic [23:0] i, input logic [3:0] c, input logic [11:0] p,
                              input logic f, input logic x, input logic [1:0] op,
                              input logic [11:0] tg, input logic [2:0] cnt);
    vec_t t;
    t.rst = r; t.en = e; t.valid = v; t.ir = i; t.ccr = c; t.pc = p;
    t.f = f; t.x = x; t.op = op; t.tg = tg; t.cnt = cnt; t.ov = 1'b0; t.un = 1'b0;
    return t;
  endfunction

  // Reference model: one instruction at a time, return stack as a queue.
  typedef enum int {M_IDLE, M_WAIT_IR, M_RESOLVE, M_FLAGS, M_RUN} mph_t;
  mph_t        m_ph  = M_IDLE;
  logic [23:0] m_ir  = '0;
  logic [11:0] m_stk[$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;

  task automatic model_step(input logic r, input logic e, input logic v,
                            input logic [23:0] i, input logic [3:0] c, input logic [11:0] p,
                            output logic f, output logic x, output logic [1:0] op,
                            output logic [11:0] tg, output logic [2:0] cnt,
                            output logic ov, output logic un);
    int   opc = int'(m_ir[23:12]);
    int   imm = int'(m_ir[11:0]);
    bit   take;
    f = 1'b0; x = 1'b0; op = 2'd0; tg = '0;
    cnt = 3'(m_stk.size()); ov = m_ovf; un = m_unf;
    if (e) begin
      case (m_ph)
        M_IDLE: m_ph = M_WAIT_IR;
        M_WAIT_IR: begin
          f = 1'b1;
          if (v) begin m_ir = i; m_ph = M_RESOLVE; end
        end
        M_RESOLVE: begin
          m_ph = M_WAIT_IR;
          if (opc == 'h800) begin
            op = 2'd2; tg = 12'(imm);
          end else if (opc >= 'h801 && opc <= 'h803) begin
            m_ph = M_FLAGS;
          end else if (opc == 'h804) begin
            if (m_stk.size() > 0) begin op = 2'd2; tg = m_stk.pop_back(); end
            else begin m_unf = 1'b1; op = 2'd1; end
          end else if (opc == 'h805) begin
            if (m_stk.size() < SD) begin
              m_stk.push_back(12'((int'(p) + 1) % 4096));
              op = 2'd2; tg = 12'((int'(p) + imm) % 4096);
            end else begin
              m_ovf = 1'b1; op = 2'd1;
            end
          end else begin
            m_ph = M_RUN;
          end
        end
        M_FLAGS: begin
          take = (opc == 'h801) ? c[2] : (opc == 'h802) ? c[3] : c[0];
          op = take ? 2'd2 : 2'd1;
          tg = take ? 12'(imm) : 12'h000;
          m_ph = M_WAIT_IR;
        end
        M_RUN: begin
          x = 1'b1; op = 2'd1; m_ph = M_WAIT_IR;
        end
        default: m_ph = M_IDLE;
      endcase
    end
    if (r) begin
      m_ph = M_IDLE; m_ir = '0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end
  endtask

  initial begin
    logic ef, ex, eov, eun;
    logic [1:0] eop;
    logic [11:0] etg;
    logic [2:0] ecnt;
    logic r, e, v;
    logic [23:0] i;
    int k;

    // rst, en, valid, ir, ccr, pc | fetch, exec, pc_op, target, stack_cnt
    vq.push_back(mk(1,1,0,24'h000000,4'h0,12'h000, 0,0,2'd0,12'h000,3'd0)); // reset state
    vq.push_back(mk(0,1,0,24'h000000,4'h0,12'h000, 0,0,2'd0,12'h000,3'd0)); // idle
    vq.push_back(mk(0,1,1,24'h000123,4'h0,12'h000, 1,0,2'd0,12'h000,3'd0)); // fetch non-branch
    vq.push_back(mk(0,1,1,24'h800FFF,4'h0,12'h000, 0,0,2'd0,12'h000,3'd0)); // decode, stray ir_valid
    vq.push_back(mk(0,1,0,24'h000000,4'h0,12'h000, 0,1,2'd1,12'h000,3'd0)); // exec
    vq.push_back(mk(0,1,1,24'h800ABC,4'h0,12'h010, 1,0,2'd0,12'h000,3'd0)); // fetch JMP
    vq.push_back(mk(0,1,0,24'h000000,4'h0,12'h010, 0,0,2'd2,12'hABC,3'd0)); // JMP load
    vq.push_back(mk(0,1,1,24'h801050,4'h0,12'h000, 1,0,2'd0,12'h000,3'd0)); // fetch JZE
    vq.push_back(mk(0,1,0,24'h000000,4'h0,12'h000, 0,0,2'd0,12'h000,3'd0)); // decode
    vq.push_back(mk(0,1,0,24'h000000,4'h4,12'h000, 0,0,2'd2,12'h050,3'd0)); // cond Z=1 taken
    vq.push_back(mk(0,1,1,24'h801050,4'h0,12'h000, 1,0,2'd0,12'h000,3'd0)); // fetch JZE
    vq.push_back(mk(0,1,0,24'h000000,4'h4,12'h000, 0,0,2'd0,12'h000,3'd0)); // decode, Z=1 ignored
    vq.push_back(mk(0,1,0,24'h000000,4'h0,12'h000, 0,0,2'd1,12'h000,3'd0)); // cond Z=0 not taken
    vq.push_back(mk(0,1,1,24'h805020,4'h0,12'hFF0, 1,0,2'd0,12'h000,3'd0)); // fetch BSR
    vq.push_back(mk(0,1,0,24'h000000,4'h0,12'hFF0, 0,0,2'd2,12'h010,3'd0)); // BSR wrap target
    vq.push_back(mk(0,1,1,24'h804000,4'h0,12'h010, 1,0,2'd0,12'h000,3'd1)); // fetch RET
    vq.push_back(mk(0,1,0,24'h000000,4'h0,12'h010, 0,0,2'd2,12'hFF1,3'd1)); // RET pops FF1
    vq.push_back(mk(0,1,1,24'h802100,4'h0,12'h000, 1,0,2'd0,12'h000,3'd0)); // fetch JNE
    vq.push_back(mk(0,1,0,24'h000000,4'h8,12'h000, 0,0,2'd0,12'h000,3'd0)); // decode
    vq.push_back(mk(0,1,0,24'h000000,4'h8,12'h000, 0,0,2'd2,12'h100,3'd0)); // cond N=1 taken
    vq.push_back(mk(0,1,1,24'h803200,4'h0,12'h000, 1,0,2'd0,12'h000,3'd0)); // fetch JCY
    vq.push_back(mk(0,1,0,24'h000000,4'h0,12'h000, 0,0,2'd0,12'h000,3'd0)); // decode
    vq.push_back(mk(0,1,0,24'h000000,4'hE,12'h000, 0,0,2'd1,12'h000,3'd0)); // cond CY=0 not taken
    vq.push_back(mk(0,1,0,24'h000000,4'h0,12'h000, 1,0,2'd0,12'h000,3'd0)); // waiting in fetch

    drive(1, 0, 0, 24'h0, 4'h0, 12'h0);
    drive(1, 0, 0, 24'h0, 4'h0, 12'h0);
    foreach (vq[n]) begin
      drive(vq[n].rst, vq[n].en, vq[n].valid, vq[n].ir, vq[n].ccr, vq[n].pc);
      check_out($sformatf("vec%0d", n), vq[n].f, vq[n].x, vq[n].op, vq[n].tg,
                vq[n].cnt, vq[n].ov, vq[n].un);
    end

    // Fill the stack; the fifth BSR takes the overflow path.
    drive(1, 1, 0, 24'h0, 4'h0, 12'h0);
    drive(0, 1, 0, 24'h0, 4'h0, 12'h0);
    check_out("ovf.idle", 0, 0, 2'd0, 12'h000, 3'd0, 0, 0);
    for (int b = 0; b < 5; b++) begin
      drive(0, 1, 1, 24'h805040, 4'h0, 12'(12'h100 + b));
      check_out($sformatf("ovf.fetch%0d", b), 1, 0, 2'd0, 12'h000, 3'(b), 0, 0);
      drive(0, 1, 0, 24'h0, 4'h0, 12'(12'h100 + b));
      if (b < SD)
        check_out($sformatf("ovf.bsr%0d", b), 0, 0, 2'd2, 12'(12'h140 + b), 3'(b), 0, 0);
      else
        check_out("ovf.bsr_full", 0, 0, 2'd1, 12'h000, 3'd4, 0, 0);
    end
    drive(0, 1, 0, 24'h0, 4'h0, 12'h0);
    check_out("ovf.sticky", 1, 0, 2'd0, 12'h000, 3'd4, 1, 0);

    // RET on an empty stack right after reset.
    drive(1, 1, 0, 24'h0, 4'h0, 12'h0);
    drive(0, 1, 0, 24'h0, 4'h0, 12'h0);
    check_out("unf.idle", 0, 0, 2'd0, 12'h000, 3'd0, 0, 0);
    drive(0, 1, 1, 24'h804000, 4'h0, 12'h0);
    check_out("unf.fetch", 1, 0, 2'd0, 12'h000, 3'd0, 0, 0);
    drive(0, 1, 0, 24'h0, 4'h0, 12'h0);
    check_out("unf.ret", 0, 0, 2'd1, 12'h000, 3'd0, 0, 0);
    drive(0, 1, 0, 24'h0, 4'h0, 12'h0);
    check_out("unf.sticky", 1, 0, 2'd0, 12'h000, 3'd0, 0, 1);

    // Enable dropped for three cycles while in COND.
    drive(0, 1, 1, 24'h801050, 4'h0, 12'h0);
    check_out("hold.fetch", 1, 0, 2'd0, 12'h000, 3'd0, 0, 1);
    drive(0, 1, 0, 24'h0, 4'h4, 12'h0);
    check_out("hold.decode", 0, 0, 2'd0, 12'h000, 3'd0, 0, 1);
    for (int h = 0; h < 3; h++) begin
      drive(0, 0, 1, 24'h800777, 4'h4, 12'h0);
      check_out($sformatf("hold.off%0d", h), 0, 0, 2'd0, 12'h000, 3'd0, 0, 1);
    end
    drive(0, 1, 0, 24'h0, 4'h4, 12'h0);
    check_out("hold.resume", 0, 0, 2'd2, 12'h050, 3'd0, 0, 1);
    drive(0, 1, 0, 24'h0, 4'h4, 12'h0);
    check_out("hold.after", 1, 0, 2'd0, 12'h000, 3'd0, 0, 1);

    // Reset while in EXEC with a non-empty stack.
    drive(0, 1, 1, 24'h805010, 4'h0, 12'h200);
    check_out("rex.fetch_bsr", 1, 0, 2'd0, 12'h000, 3'd0, 0, 1);
    drive(0, 1, 0, 24'h0, 4'h0, 12'h200);
    check_out("rex.bsr", 0, 0, 2'd2, 12'h210, 3'd0, 0, 1);
    drive(0, 1, 1, 24'h000777, 4'h0, 12'h210);
    check_out("rex.fetch_nb", 1, 0, 2'd0, 12'h000, 3'd1, 0, 1);
    drive(0, 1, 0, 24'h0, 4'h0, 12'h210);
    check_out("rex.decode", 0, 0, 2'd0, 12'h000, 3'd1, 0, 1);
    drive(1, 1, 0, 24'h0, 4'h0, 12'h210);
    check_out("rex.exec", 0, 1, 2'd1, 12'h000, 3'd1, 0, 1);
    drive(0, 1, 0, 24'h0, 4'h0, 12'h210);
    check_out("rex.after_rst", 0, 0, 2'd0, 12'h000, 3'd0, 0, 0);

    // Randomized run against the reference model.
    drive(1, 1, 0, 24'h0, 4'h0, 12'h0);
    model_step(1, 1, 0, 24'h0, 4'h0, 12'h0, ef, ex, eop, etg, ecnt, eov, eun);
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 7) != 0);
      v = ($urandom_range(0, 2) != 0);
      k = $urandom_range(0, 9);
      if (k <= 5) i = {12'(12'h800 + k), 12'($urandom)};
      else        i = 24'($urandom);
      drive(r, e, v, i, 4'($urandom), 12'($urandom));
      model_step(r, e, v, i, ccr, pc, ef, ex, eop, etg, ecnt, eov, eun);
      check_out($sformatf("rnd%0d", c), ef, ex, eop, etg, ecnt, eov, eun);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
